// File: rtl/ddr_word_writer.sv
`default_nettype none
// ============================================================================
// Module  : ddr_word_writer
// Desc    : Buffers completed 128-bit groups in a small FIFO and writes them to
//           DDR over a MIG-style app interface; WRITER_STATS_EN adds stall_cycles.
// Rev     : 1.0 - initial release
// ============================================================================
module ddr_word_writer #(
    parameter int ADDR_WIDTH = 28,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_STEP  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_words,
    input  logic                  grp_ready,
    input  logic [127:0]          grp_data,
    input  logic                  app_rdy,
    output logic                  app_en,
    output logic [2:0]            app_cmd,
    output logic [ADDR_WIDTH-1:0] app_addr,
    input  logic                  app_wdf_rdy,
    output logic                  app_wdf_wren,
    output logic [127:0]          app_wdf_data,
    output logic                  app_wdf_end,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  words_written
`ifdef WRITER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall_cycles
`endif
);

    localparam int         c_ptr_w = $clog2(FIFO_DEPTH);
    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_run   = 2'd1;
    localparam logic [1:0] c_fin   = 2'd2;

    logic [1:0]            r_state;
    logic                  r_grp_prev;
    logic [127:0]          r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_ptr_w:0]      r_count;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [127:0]          r_data;
    logic [CNT_WIDTH-1:0]  r_remaining;
    logic [CNT_WIDTH-1:0]  r_to_push;
    logic [CNT_WIDTH-1:0]  r_words;
    logic                  r_pres;
    logic                  r_app_en;
    logic                  r_wren;
    logic                  r_cmd_ok;
    logic                  r_dat_ok;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_overflow;

    logic w_event;
    logic w_full;
    logic w_empty;
    logic w_cmd_acc;
    logic w_dat_acc;
    logic w_pop;
    logic w_want;
    logic w_push;
    logic w_ovf_evt;

    assign w_event   = grp_ready & ~r_grp_prev;
    assign w_full    = (r_count == (c_ptr_w+1)'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_cmd_acc = r_app_en & app_rdy;
    assign w_dat_acc = r_wren & app_wdf_rdy;
    // A word retires once both halves are in, whether latched earlier or accepted now
    assign w_pop     = (r_state == c_run) & r_pres & (r_cmd_ok | w_cmd_acc) & (r_dat_ok | w_dat_acc);
    assign w_want    = w_event & r_busy & (r_to_push != '0);
    assign w_push    = w_want & (~w_full | w_pop);
    assign w_ovf_evt = w_want & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= grp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_idle;
            r_grp_prev  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_remaining <= '0;
            r_to_push   <= '0;
            r_words     <= '0;
            r_pres      <= 1'b0;
            r_app_en    <= 1'b0;
            r_wren      <= 1'b0;
            r_cmd_ok    <= 1'b0;
            r_dat_ok    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_grp_prev <= grp_ready;
            r_done     <= 1'b0;
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + 1'b1;
                r_to_push <= r_to_push - 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + (c_ptr_w+1)'(w_push) - (c_ptr_w+1)'(w_pop);
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_addr      <= base_addr;
                        r_remaining <= num_words;
                        r_to_push   <= num_words;
                        r_words     <= '0;
                        r_overflow  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= (num_words == '0) ? c_fin : c_run;
                    end
                end
                c_run: begin
                    if (w_pop) begin
                        r_pres      <= 1'b0;
                        r_app_en    <= 1'b0;
                        r_wren      <= 1'b0;
                        r_cmd_ok    <= 1'b0;
                        r_dat_ok    <= 1'b0;
                        r_addr      <= r_addr + ADDR_WIDTH'(ADDR_STEP);
                        r_words     <= r_words + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == CNT_WIDTH'(1)) begin
                            r_state <= c_fin;
                        end
                    end else if (r_pres) begin
                        if (w_cmd_acc) begin
                            r_app_en <= 1'b0;
                            r_cmd_ok <= 1'b1;
                        end
                        if (w_dat_acc) begin
                            r_wren   <= 1'b0;
                            r_dat_ok <= 1'b1;
                        end
                    end else if (!w_empty) begin
                        r_pres   <= 1'b1;
                        r_app_en <= 1'b1;
                        r_wren   <= 1'b1;
                        r_data   <= r_mem[r_rd_ptr];
                    end
                end
                c_fin: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

`ifdef WRITER_STATS_EN
    logic [CNT_WIDTH-1:0] r_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
        end else if ((r_state == c_idle) && start) begin
            r_stall <= '0;
        end else if ((r_state == c_run) && ((r_app_en & ~app_rdy) | (r_wren & ~app_wdf_rdy))
                     && (r_stall != '1)) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign stall_cycles = r_stall;
`endif

    assign app_en        = r_app_en;
    assign app_cmd       = 3'b000;
    assign app_addr      = r_addr;
    assign app_wdf_wren  = r_wren;
    assign app_wdf_data  = r_data;
    assign app_wdf_end   = r_wren;
    assign busy          = r_busy;
    assign done          = r_done;
    assign overflow      = r_overflow;
    assign words_written = r_words;

endmodule
`default_nettype wire

// File: doc/ddr_word_writer.md
Name: ddr_word_writer

Overview:
- Downstream of the 16-byte grouper: captures each completed 128-bit group and writes it to DDR through a MIG-style native app interface.
- Addresses start at a programmable base and advance once per word; a run ends after a programmed word count.
- A small FIFO absorbs DDR back-pressure so the byte stream feeding the grouper never stalls.

Parameters:
- ADDR_WIDTH, 28, width of app_addr and base_addr.
- FIFO_DEPTH, 4, entries of 128-bit buffering; must be a power of 2, at least 2.
- ADDR_STEP, 8, address increment per 128-bit word (8 x 16-bit DDR beats).
- CNT_WIDTH, 16, width of num_words and words_written.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; loads base_addr/num_words and arms a run
- base_addr  in  ADDR_WIDTH  first DDR address of the run
- num_words  in  CNT_WIDTH  words to write in the run; 0 means finish immediately
- grp_ready  in  1  grouper ready level; high from completion of a group until its next byte 0
- grp_data  in  128  grouper data_out; stable while grp_ready is high
- app_rdy  in  1  DDR command accept
- app_en  out  1  command valid
- app_cmd  out  3  command; always 3'b000 (write)
- app_addr  out  ADDR_WIDTH  command address
- app_wdf_rdy  in  1  DDR write-data accept
- app_wdf_wren  out  1  write-data valid
- app_wdf_data  out  128  write data
- app_wdf_end  out  1  equals app_wdf_wren (single-beat word)
- busy  out  1  run in progress
- done  out  1  one-cycle pulse when the last word's command and data are both accepted
- overflow  out  1  sticky; a group was lost because the FIFO was full
- words_written  out  CNT_WIDTH  words fully accepted in the current run

Behaviour:
- Reset:
  - All outputs 0; FIFO empty; state IDLE.
  - Reset mid-run discards the FIFO and any in-flight word; no done pulse.
- Capture:
  - grp_prev holds grp_ready delayed by one clock.
  - A capture event is grp_ready & ~grp_prev.
  - Each event pushes grp_data to the FIFO if busy and the FIFO is not full.
  - Events while not busy are ignored.
  - An event while busy with the FIFO full drops the word and sets overflow. overflow clears only on rst or start.
  - Words beyond num_words (pushes counted separately) are not pushed.
  - A push and a pop in the same cycle are both allowed, including when the FIFO is full.
- FSM:
  - IDLE: start -> load addr = base_addr, remaining = num_words, clear words_written and overflow, busy = 1, go to RUN. If num_words == 0, go to FIN instead.
  - RUN: when the FIFO is not empty, present its head word:
    - app_en = 1 until app_rdy is seen; latch cmd_ok.
    - app_wdf_wren = 1 until app_wdf_rdy is seen; latch dat_ok.
    - Command and data are accepted independently, in either order or the same cycle.
    - When both are accepted (latched or current cycle): pop, addr += ADDR_STEP, words_written += 1, clear cmd_ok/dat_ok.
    - The next word may be presented on the following cycle (at most 1 word per 2 cycles is acceptable; 1 per cycle is allowed).
    - After the last word is accepted, go to FIN.
  - FIN: done = 1 for one cycle, busy = 0, go to IDLE.
- start while busy is ignored.
- Outputs are registered; app_addr and app_wdf_data stay stable while their valid is high and unaccepted.
- Address wraps modulo 2^ADDR_WIDTH with no flag.

Optional Feature:
- Macro: WRITER_STATS_EN.
- Defined:
  - Adds output stall_cycles [CNT_WIDTH-1:0]: counts cycles in RUN where app_en or app_wdf_wren is high but not accepted.
  - Saturates at all-ones; clears on rst and start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic run: base_addr=0x100, num_words=3, app_rdy=app_wdf_rdy=1, three groups 0x00..0F, 0x10..1F, 0x20..2F -> writes at 0x100/0x108/0x110 with matching data, words_written=3, one done pulse, busy falls.
- Split handshake: app_rdy high 2 cycles before app_wdf_rdy -> app_en drops after accept, wren holds until accept, pop only after both, address unchanged until then.
- Back-pressure/overflow: app_rdy=0, FIFO_DEPTH=4, 5 groups -> 4 buffered, overflow=1 on the 5th; release -> 4 writes in order.
- Level vs edge: grp_ready held high 10 cycles -> exactly one capture.
- num_words=0 -> done pulse 2 cycles after start, no app_en.
- rst asserted mid-run with 2 words queued -> all outputs 0, no further app_en, next start behaves as fresh.
